// File: rtl/mul_batch_ctrl_pkg.sv
// Shared definitions for the RTLinf job controllers: FSM state encodings,
// default count widths and a small state-decode helper.
package mul_batch_ctrl_pkg;

    localparam int DEF_LOG_MAX_ITERS          = 16;
    localparam int DEF_LOG_MAX_READS_PER_ITER = 16;

    localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
    localparam logic [2:0] ST_CONFIG_ENC = 3'd1;
    localparam logic [2:0] ST_SETTLE_ENC = 3'd2;
    localparam logic [2:0] ST_RUN_ENC    = 3'd3;
    localparam logic [2:0] ST_DONE_ENC   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = ST_IDLE_ENC,
        ST_CONFIG = ST_CONFIG_ENC,
        ST_SETTLE = ST_SETTLE_ENC,
        ST_RUN    = ST_RUN_ENC,
        ST_DONE   = ST_DONE_ENC
    } ctrl_state_t;

    function automatic logic state_is_busy(ctrl_state_t s);
        return (s != ST_IDLE);
    endfunction

endpackage

// File: rtl/mul_batch_ctrl_beat_counter.sv
// Two-level nested beat counter: reads within an iteration, then iterations.
// The last flag marks the beat that completes the final iteration.
module mul_batch_ctrl_beat_counter
    import mul_batch_ctrl_pkg::*;
#(
    parameter int LOG_MAX_ITERS          = DEF_LOG_MAX_ITERS,
    parameter int LOG_MAX_READS_PER_ITER = DEF_LOG_MAX_READS_PER_ITER
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear,
    input  logic                              en,
    input  logic [LOG_MAX_ITERS-1:0]          iters_lim,
    input  logic [LOG_MAX_READS_PER_ITER-1:0] reads_lim,
    output logic [LOG_MAX_ITERS-1:0]          iter_cnt,
    output logic [LOG_MAX_READS_PER_ITER-1:0] read_cnt,
    output logic                              last
);

    logic read_wrap;

    // Limits are non-zero whenever en can be high, so limit-1 never underflows.
    assign read_wrap = (read_cnt == reads_lim - LOG_MAX_READS_PER_ITER'(1));
    assign last      = read_wrap && (iter_cnt == iters_lim - LOG_MAX_ITERS'(1));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            read_cnt <= '0;
            iter_cnt <= '0;
        end else if (en) begin
            if (read_wrap) begin
                read_cnt <= '0;
                iter_cnt <= iter_cnt + LOG_MAX_ITERS'(1);
            end else begin
                read_cnt <= read_cnt + LOG_MAX_READS_PER_ITER'(1);
            end
        end
    end

endmodule

// File: rtl/mul_batch_ctrl.sv
// Job sequencer for one MUL_BATCH instance: configures the batch, gates the
// input stream while running, counts snooped output beats and signals done.
module mul_batch_ctrl
    import mul_batch_ctrl_pkg::*;
#(
    parameter int LOG_MAX_ITERS          = DEF_LOG_MAX_ITERS,
    parameter int LOG_MAX_READS_PER_ITER = DEF_LOG_MAX_READS_PER_ITER
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              job_valid_in,
    output logic                              job_avail_out,
    input  logic [LOG_MAX_ITERS-1:0]          job_iters_in,
    input  logic [LOG_MAX_READS_PER_ITER-1:0] job_reads_in,
    output logic                              configure_out,
    output logic [LOG_MAX_ITERS-1:0]          num_iters_out,
    output logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter_out,
    output logic                              run_out,
    input  logic                              mon_valid_in,
    input  logic                              mon_avail_in,
    output logic [LOG_MAX_ITERS-1:0]          cur_iter_out,
    output logic                              busy_out,
    output logic                              done_out,
    output logic                              stray_err_out
);

    ctrl_state_t                     state;
    logic                            beat;
    logic                            accept;
    logic                            count_en;
    logic                            last_beat;
    logic [LOG_MAX_READS_PER_ITER-1:0] read_cnt;

    // Availability depends only on state and reset, never on job_valid_in.
    assign job_avail_out = (state == ST_IDLE) && !rst;
    assign accept        = job_valid_in && job_avail_out;
    assign beat          = mon_valid_in && mon_avail_in;
    assign count_en      = beat && (state == ST_RUN);

    mul_batch_ctrl_beat_counter #(
        .LOG_MAX_ITERS          (LOG_MAX_ITERS),
        .LOG_MAX_READS_PER_ITER (LOG_MAX_READS_PER_ITER)
    ) u_beat_counter (
        .clk       (clk),
        .rst       (rst),
        .clear     (accept),
        .en        (count_en),
        .iters_lim (num_iters_out),
        .reads_lim (num_reads_per_iter_out),
        .iter_cnt  (cur_iter_out),
        .read_cnt  (read_cnt),
        .last      (last_beat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state                  <= ST_IDLE;
            configure_out          <= 1'b0;
            run_out                <= 1'b0;
            done_out               <= 1'b0;
            busy_out               <= 1'b0;
            stray_err_out          <= 1'b0;
            num_iters_out          <= '0;
            num_reads_per_iter_out <= '0;
        end else begin
            configure_out <= 1'b0;
            done_out      <= 1'b0;
            if (beat && (state != ST_RUN))
                stray_err_out <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (job_valid_in) begin
                        busy_out <= 1'b1;
                        if ((job_iters_in != '0) && (job_reads_in != '0)) begin
                            num_iters_out          <= job_iters_in;
                            num_reads_per_iter_out <= job_reads_in;
                            configure_out          <= 1'b1;
                            state                  <= ST_CONFIG;
                        end else begin
                            // Empty job: report completion without touching the batch.
                            done_out <= 1'b1;
                            state    <= ST_DONE;
                        end
                    end
                end
                ST_CONFIG: state <= ST_SETTLE;
                ST_SETTLE: begin
                    run_out <= 1'b1;
                    state   <= ST_RUN;
                end
                ST_RUN: begin
                    if (count_en && last_beat) begin
                        run_out  <= 1'b0;
                        done_out <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_out <= state_is_busy(ST_IDLE);
                    state    <= ST_IDLE;
                end
                default: begin
                    run_out  <= 1'b0;
                    busy_out <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_batch_ctrl.sv
// Directed-vector bench for mul_batch_ctrl with hand-computed expectations.
module tb_mul_batch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        job_valid_in;
    logic        job_avail_out;
    logic [15:0] job_iters_in;
    logic [15:0] job_reads_in;
    logic        configure_out;
    logic [15:0] num_iters_out;
    logic [15:0] num_reads_per_iter_out;
    logic        run_out;
    logic        mon_valid_in;
    logic        mon_avail_in;
    logic [15:0] cur_iter_out;
    logic        busy_out;
    logic        done_out;
    logic        stray_err_out;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    mul_batch_ctrl dut (
        .clk                    (clk),
        .rst                    (rst),
        .job_valid_in           (job_valid_in),
        .job_avail_out          (job_avail_out),
        .job_iters_in           (job_iters_in),
        .job_reads_in           (job_reads_in),
        .configure_out          (configure_out),
        .num_iters_out          (num_iters_out),
        .num_reads_per_iter_out (num_reads_per_iter_out),
        .run_out                (run_out),
        .mon_valid_in           (mon_valid_in),
        .mon_avail_in           (mon_avail_in),
        .cur_iter_out           (cur_iter_out),
        .busy_out               (busy_out),
        .done_out               (done_out),
        .stray_err_out          (stray_err_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then stable for the new cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a job for one cycle, then move to the cycle after acceptance.
    task automatic give_job(input logic [15:0] it, input logic [15:0] rd);
        job_valid_in = 1'b1;
        job_iters_in = it;
        job_reads_in = rd;
        step();
        job_valid_in = 1'b0;
    endtask

    // Apply n back-to-back beats; returns in the cycle after the last beat.
    task automatic beats(input int n);
        for (int i = 0; i < n; i++) begin
            mon_valid_in = 1'b1;
            mon_avail_in = 1'b1;
            step();
        end
        mon_valid_in = 1'b0;
        mon_avail_in = 1'b0;
    endtask

    // From the cycle after accept, wait for run_out; expects it two cycles later.
    task automatic wait_run(input string tag);
        int cyc = 1;
        while (!run_out && cyc < 20) begin
            step();
            cyc++;
        end
        check(tag, 32'(cyc), 32'd3);
    endtask

    int  qual;
    logic early_done;
    logic saw_cfg;
    logic avail_seen;

    initial begin
        rst          = 1'b1;
        job_valid_in = 1'b0;
        job_iters_in = '0;
        job_reads_in = '0;
        mon_valid_in = 1'b0;
        mon_avail_in = 1'b0;
        step();
        check("avail_during_rst", job_avail_out, 1'b0);
        step();
        rst = 1'b0;
        #1;
        check("rst_avail",    job_avail_out, 1'b1);
        check("rst_cfg",      configure_out, 1'b0);
        check("rst_run",      run_out,       1'b0);
        check("rst_busy",     busy_out,      1'b0);
        check("rst_done",     done_out,      1'b0);
        check("rst_stray",    stray_err_out, 1'b0);
        check("rst_cur_iter", cur_iter_out,  16'd0);
        check("rst_num_it",   num_iters_out, 16'd0);

        // Basic 2x3 job.
        give_job(16'd2, 16'd3);
        check("j1_cfg_t1",   configure_out,          1'b1);
        check("j1_busy_t1",  busy_out,               1'b1);
        check("j1_avail_t1", job_avail_out,          1'b0);
        check("j1_num_it",   num_iters_out,          16'd2);
        check("j1_num_rd",   num_reads_per_iter_out, 16'd3);
        check("j1_run_t1",   run_out,                1'b0);
        step();
        check("j1_cfg_t2",   configure_out, 1'b0);
        check("j1_run_t2",   run_out,       1'b0);
        step();
        check("j1_run_t3",   run_out,       1'b1);
        beats(3);
        check("j1_iter_mid", cur_iter_out,  16'd1);
        check("j1_run_mid",  run_out,       1'b1);
        beats(2);
        check("j1_no_done5", done_out,      1'b0);
        beats(1);
        check("j1_done",     done_out,      1'b1);
        check("j1_run_off",  run_out,       1'b0);
        check("j1_iter_fin", cur_iter_out,  16'd2);
        step();
        check("j1_done_1cy", done_out,      1'b0);
        check("j1_idle",     job_avail_out, 1'b1);
        check("j1_iter_hold", cur_iter_out, 16'd2);
        check("j1_stray",    stray_err_out, 1'b0);

        // 2x3 job with valid held and avail toggling.
        give_job(16'd2, 16'd3);
        check("j2_iter_clr", cur_iter_out, 16'd0);
        wait_run("j2_run_lat");
        qual = 0;
        early_done = 1'b0;
        for (int c = 0; c < 40 && qual < 6; c++) begin
            mon_valid_in = 1'b1;
            mon_avail_in = c[0];
            step();
            if (c[0]) qual++;
            if (qual < 6 && done_out) early_done = 1'b1;
        end
        mon_valid_in = 1'b0;
        mon_avail_in = 1'b0;
        check("j2_no_early_done", early_done,   1'b0);
        check("j2_done",          done_out,     1'b1);
        check("j2_iter",          cur_iter_out, 16'd2);
        step();
        check("j2_stray",         stray_err_out, 1'b0);

        // Zero-iteration job.
        give_job(16'd0, 16'd5);
        check("z_done_t1", done_out,               1'b1);
        check("z_cfg_t1",  configure_out,          1'b0);
        check("z_num_it",  num_iters_out,          16'd2);
        check("z_num_rd",  num_reads_per_iter_out, 16'd3);
        check("z_busy_t1", busy_out,               1'b1);
        step();
        check("z_avail_t2", job_avail_out, 1'b1);
        check("z_done_t2",  done_out,      1'b0);
        check("z_busy_t2",  busy_out,      1'b0);

        // Stray beat in IDLE, held through a 1x1 job, cleared by reset.
        beats(1);
        check("s_stray_set",  stray_err_out, 1'b1);
        check("s_idle_nocnt", cur_iter_out,  16'd0);
        give_job(16'd1, 16'd1);
        wait_run("s_run_lat");
        beats(1);
        check("s_done",     done_out,      1'b1);
        check("s_iter",     cur_iter_out,  16'd1);
        check("s_stray_hold", stray_err_out, 1'b1);
        step();
        check("s_stray_idle", stray_err_out, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("s_stray_clr", stray_err_out, 1'b0);

        // Reset mid-run after 2 of 6 beats.
        give_job(16'd2, 16'd3);
        wait_run("r_run_lat");
        beats(2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("r_run_off", run_out,       1'b0);
        check("r_busy",    busy_out,      1'b0);
        check("r_done",    done_out,      1'b0);
        check("r_avail",   job_avail_out, 1'b1);
        step();
        check("r_no_done_late", done_out, 1'b0);
        give_job(16'd1, 16'd2);
        wait_run("r2_run_lat");
        beats(1);
        check("r2_no_done1", done_out, 1'b0);
        beats(1);
        check("r2_done",     done_out,     1'b1);
        check("r2_iter",     cur_iter_out, 16'd1);
        step();

        // job_valid held across done: second job accepted right after done.
        job_valid_in = 1'b1;
        job_iters_in = 16'd1;
        job_reads_in = 16'd1;
        step();
        avail_seen = 1'b0;
        if (job_avail_out) avail_seen = 1'b1;
        step();
        if (job_avail_out) avail_seen = 1'b1;
        step();
        check("b_run", run_out, 1'b1);
        if (job_avail_out) avail_seen = 1'b1;
        mon_valid_in = 1'b1;
        mon_avail_in = 1'b1;
        step();
        mon_valid_in = 1'b0;
        mon_avail_in = 1'b0;
        check("b_done1", done_out, 1'b1);
        if (job_avail_out) avail_seen = 1'b1;
        check("b_avail_low", avail_seen, 1'b0);
        step();
        check("b_avail_after_done", job_avail_out, 1'b1);
        saw_cfg = configure_out;
        step();
        job_valid_in = 1'b0;
        check("b_cfg_pre", saw_cfg,       1'b0);
        check("b_cfg2",    configure_out, 1'b1);
        check("b_busy2",   busy_out,      1'b1);
        wait_run("b2_run_lat");
        beats(1);
        check("b2_done", done_out, 1'b1);
        check("b2_stray", stray_err_out, 1'b0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
